// File: rtl/inst_fetcher.sv
// Instruction fetch engine: icache hit path, 4-byte little-endian miss refill over a byte bus.
// Latency: hit 1 cycle; miss 6 cycles with continuous grant. Backpressure: mem_grant_i gaps stall issue, rdy=0 freezes all state.
// IF must hold pc_i stable until inst_valid_o; req_i is only looked at while idle.
module inst_fetcher #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush_i,
    input  logic                      req_i,
    input  logic [ADDR_WIDTH-1:0]     pc_i,
    input  logic                      icache_hit_i,
    input  logic [31:0]               icache_inst_i,
    output logic [ADDR_WIDTH-1:0]     icache_raddr_o,
    output logic                      icache_we_o,
    output logic [ADDR_WIDTH-1:0]     icache_waddr_o,
    output logic [31:0]               icache_winst_o,
    output logic                      mem_req_o,
    input  logic                      mem_grant_i,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    input  logic [MEM_DATA_WIDTH-1:0] mem_din_i,
    output logic                      inst_valid_o,
    output logic [31:0]               inst_o,
    output logic [ADDR_WIDTH-1:0]     inst_pc_o
);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [2:0]            issue_cnt;
    logic [1:0]            cap_cnt;
    logic                  pending;
    logic [23:0]           byte_buf;
    logic                  issue;
    logic [31:0]           full_word;

    assign icache_raddr_o = pc_i;
    assign issue          = mem_req_o & mem_grant_i;
    assign full_word      = {mem_din_i, byte_buf};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            base           <= '0;
            issue_cnt      <= '0;
            cap_cnt        <= '0;
            pending        <= 1'b0;
            byte_buf       <= '0;
            mem_req_o      <= 1'b0;
            mem_addr_o     <= '0;
            inst_valid_o   <= 1'b0;
            inst_o         <= '0;
            inst_pc_o      <= '0;
            icache_we_o    <= 1'b0;
            icache_waddr_o <= '0;
            icache_winst_o <= '0;
        end else if (rdy) begin
            inst_valid_o <= 1'b0;
            icache_we_o  <= 1'b0;
            if (flush_i) begin
                state     <= IDLE;
                mem_req_o <= 1'b0;
                pending   <= 1'b0;
                issue_cnt <= '0;
                cap_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_i) begin
                            if (icache_hit_i) begin
                                inst_valid_o <= 1'b1;
                                inst_o       <= icache_inst_i;
                                inst_pc_o    <= pc_i;
                            end else begin
                                base       <= pc_i;
                                issue_cnt  <= '0;
                                cap_cnt    <= '0;
                                pending    <= 1'b0;
                                mem_req_o  <= 1'b1;
                                mem_addr_o <= pc_i;
                                state      <= FETCH;
                            end
                        end
                    end
                    FETCH: begin
                        // A byte is in flight only if its address was granted last cycle.
                        pending <= issue;
                        if (issue) begin
                            issue_cnt  <= issue_cnt + 3'd1;
                            mem_addr_o <= base + ADDR_WIDTH'(issue_cnt) + ADDR_WIDTH'(1);
                            if (issue_cnt == 3'd3)
                                mem_req_o <= 1'b0;
                        end
                        if (pending) begin
                            case (cap_cnt)
                                2'd0:    byte_buf[7:0]   <= mem_din_i;
                                2'd1:    byte_buf[15:8]  <= mem_din_i;
                                2'd2:    byte_buf[23:16] <= mem_din_i;
                                default: byte_buf        <= byte_buf;
                            endcase
                            cap_cnt <= cap_cnt + 2'd1;
                            if (cap_cnt == 2'd3) begin
                                inst_valid_o   <= 1'b1;
                                inst_o         <= full_word;
                                inst_pc_o      <= base;
                                icache_we_o    <= 1'b1;
                                icache_waddr_o <= base;
                                icache_winst_o <= full_word;
                                mem_req_o      <= 1'b0;
                                pending        <= 1'b0;
                                state          <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed and randomized bench for inst_fetcher against a transaction-level memory/word model.
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst, rdy, flush_i, req_i;
    logic [31:0] pc_i;
    logic        icache_hit_i;
    logic [31:0] icache_inst_i;
    logic [31:0] icache_raddr_o;
    logic        icache_we_o;
    logic [31:0] icache_waddr_o;
    logic [31:0] icache_winst_o;
    logic        mem_req_o;
    logic        mem_grant_i;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_din_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    int checks = 0;
    int errors = 0;

    inst_fetcher #(.ADDR_WIDTH(32), .MEM_DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i), .req_i(req_i), .pc_i(pc_i),
        .icache_hit_i(icache_hit_i), .icache_inst_i(icache_inst_i),
        .icache_raddr_o(icache_raddr_o), .icache_we_o(icache_we_o),
        .icache_waddr_o(icache_waddr_o), .icache_winst_o(icache_winst_o),
        .mem_req_o(mem_req_o), .mem_grant_i(mem_grant_i), .mem_addr_o(mem_addr_o),
        .mem_din_i(mem_din_i), .inst_valid_o(inst_valid_o), .inst_o(inst_o),
        .inst_pc_o(inst_pc_o)
    );

    always #5 clk = ~clk;

    // Memory image: a few fixed bytes for the directed miss, hashed contents elsewhere.
    function automatic logic [7:0] mb(input logic [31:0] a);
        case (a)
            32'h4:   return 8'h13;
            32'h5:   return 8'h05;
            32'h6:   return 8'h10;
            32'h7:   return 8'h00;
            default: return (a[7:0] * 8'd37) ^ a[23:16] ^ a[31:24] ^ 8'h5c;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; the bus answers a granted address with its byte in the following cycle.
    task automatic tick();
        logic        iss;
        logic        frz;
        logic [31:0] a;
        iss = rst && rdy && !flush_i && mem_req_o && mem_grant_i;
        frz = rst && !rdy;
        a   = mem_addr_o;
        @(posedge clk);
        #1;
        if (!frz)
            mem_din_i = iss ? mb(a) : 8'($urandom);
    endtask

    task automatic start_miss(input logic [31:0] pc);
        pc_i = pc; icache_hit_i = 1'b0; req_i = 1'b1; mem_grant_i = 1'b1; rdy = 1'b1;
        tick();
        req_i = 1'b0;
    endtask

    // Full miss: gm/rm give grant and rdy for each FETCH cycle; exp_lat < 0 skips the latency check.
    task automatic miss_run(input logic [31:0] pc, input logic [31:0] gm, input logic [31:0] rm,
                            input int exp_lat);
        int          n_iss;
        int          lat;
        logic        done;
        logic        g, r;
        logic [31:0] pa;
        logic        preq;
        pc_i = pc; icache_hit_i = 1'b0; req_i = 1'b1; mem_grant_i = 1'b0; rdy = 1'b1;
        tick();
        req_i = 1'b0;
        chk("miss_req", 32'(mem_req_o), 32'd1);
        chk("miss_addr0", mem_addr_o, pc);
        n_iss = 0; lat = 0; done = 1'b0;
        while (!done && lat < 64) begin
            g = (lat < 32) ? gm[lat] : 1'b1;
            r = (lat < 32) ? rm[lat] : 1'b1;
            mem_grant_i = g; rdy = r;
            icache_hit_i = 1'($urandom); req_i = 1'($urandom);
            pa = mem_addr_o; preq = mem_req_o;
            if (r && mem_req_o && g) n_iss++;
            tick();
            lat++;
            if (!r) begin
                chk("freeze_addr", mem_addr_o, pa);
                chk("freeze_req", 32'(mem_req_o), 32'(preq));
            end
            if (inst_valid_o) done = 1'b1;
            else begin
                chk("req_level", 32'(mem_req_o), 32'(n_iss < 4));
                if (mem_req_o) chk("burst_addr", mem_addr_o, pc + 32'(n_iss));
            end
        end
        req_i = 1'b0; rdy = 1'b1; mem_grant_i = 1'b0;
        chk("miss_done", 32'(done), 32'd1);
        chk("miss_inst", inst_o, word_at(pc));
        chk("miss_pc", inst_pc_o, pc);
        chk("miss_we", 32'(icache_we_o), 32'd1);
        chk("miss_waddr", icache_waddr_o, pc);
        chk("miss_winst", icache_winst_o, word_at(pc));
        chk("miss_nbytes", 32'(n_iss), 32'd4);
        if (exp_lat >= 0) chk("miss_latency", 32'(lat), 32'(exp_lat));
        tick();
        chk("miss_vld_pulse", 32'(inst_valid_o), 32'd0);
        chk("miss_we_pulse", 32'(icache_we_o), 32'd0);
    endtask

    task automatic hit_run(input logic [31:0] pc, input logic [31:0] ins);
        pc_i = pc; icache_hit_i = 1'b1; icache_inst_i = ins; req_i = 1'b1; rdy = 1'b1;
        chk("hit_raddr", icache_raddr_o, pc);
        tick();
        req_i = 1'b0; icache_hit_i = 1'b0;
        chk("hit_vld", 32'(inst_valid_o), 32'd1);
        chk("hit_inst", inst_o, ins);
        chk("hit_pc", inst_pc_o, pc);
        chk("hit_we", 32'(icache_we_o), 32'd0);
        chk("hit_memreq", 32'(mem_req_o), 32'd0);
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; flush_i = 1'b0; req_i = 1'b0; pc_i = 32'h1234;
        icache_hit_i = 1'b0; icache_inst_i = '0; mem_grant_i = 1'b0; mem_din_i = '0;
        tick();
        tick();
        chk("rst_vld", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", inst_pc_o, 32'd0);
        chk("rst_memreq", 32'(mem_req_o), 32'd0);
        chk("rst_memaddr", mem_addr_o, 32'd0);
        chk("rst_we", 32'(icache_we_o), 32'd0);
        chk("rst_waddr", icache_waddr_o, 32'd0);
        chk("rst_winst", icache_winst_o, 32'd0);
        chk("rst_raddr", icache_raddr_o, 32'h1234);
        rst = 1'b1;

        hit_run(32'h1000, 32'h00A00093);
        tick();
        chk("hit_vld_pulse", 32'(inst_valid_o), 32'd0);

        // A delivered pulse is held while frozen.
        hit_run(32'h1008, 32'hDEADBEEF);
        rdy = 1'b0;
        tick();
        chk("frz_vld_hold", 32'(inst_valid_o), 32'd1);
        chk("frz_inst_hold", inst_o, 32'hDEADBEEF);
        rdy = 1'b1;
        tick();
        chk("frz_vld_clear", 32'(inst_valid_o), 32'd0);

        miss_run(32'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        chk("miss_word_const", inst_o, 32'h00100513);
        miss_run(32'h4, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 7);
        miss_run(32'h30, 32'hFFFF_FFFF, 32'hFFFF_FFE3, 8);

        // Flush after two bytes captured.
        start_miss(32'h100);
        for (int i = 0; i < 3; i++) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_memreq", 32'(mem_req_o), 32'd0);
        chk("flush_vld", 32'(inst_valid_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_no_vld", 32'(inst_valid_o), 32'd0);
            chk("flush_no_we", 32'(icache_we_o), 32'd0);
            chk("flush_no_req", 32'(mem_req_o), 32'd0);
        end
        miss_run(32'h2000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);

        // Flush coinciding with the completing edge suppresses delivery and fill.
        start_miss(32'h80);
        for (int i = 0; i < 4; i++) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_cmpl_vld", 32'(inst_valid_o), 32'd0);
        chk("flush_cmpl_we", 32'(icache_we_o), 32'd0);

        // Request alongside flush is dropped.
        pc_i = 32'h3000; icache_hit_i = 1'b1; icache_inst_i = 32'h1111_2222;
        req_i = 1'b1; flush_i = 1'b1;
        tick();
        req_i = 1'b0; flush_i = 1'b0; icache_hit_i = 1'b0;
        chk("flush_req_vld", 32'(inst_valid_o), 32'd0);
        chk("flush_req_memreq", 32'(mem_req_o), 32'd0);

        // Reset in the middle of a burst.
        start_miss(32'h40);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_memreq", 32'(mem_req_o), 32'd0);
        chk("mrst_memaddr", mem_addr_o, 32'd0);
        chk("mrst_vld", 32'(inst_valid_o), 32'd0);
        chk("mrst_inst", inst_o, 32'd0);
        chk("mrst_we", 32'(icache_we_o), 32'd0);
        tick();
        chk("mrst_idle", 32'(mem_req_o), 32'd0);
        miss_run(32'h44, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);

        // Randomized mix of hits and misses with random grant and rdy gaps.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 2) == 0) begin
                hit_run(pc, $urandom);
                tick();
                chk("rhit_pulse", 32'(inst_valid_o), 32'd0);
            end else begin
                miss_run(pc, $urandom, $urandom | $urandom | $urandom, -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Instruction fetch engine between the IF stage, the direct-mapped icache and the byte-wide memory bus.
- On a fetch request it consults the icache read result. On a hit it returns the cached word.
- On a miss it reads four bytes over the memory bus, assembles a little-endian word, returns it to IF and drives the icache write port (we, waddr, winst) to fill the line.

Parameters:
ADDR_WIDTH, 32, width of PC and memory byte address
MEM_DATA_WIDTH, 8, memory bus data width (byte bus; fixed at 8)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low (rst==0 resets on posedge clk)
rdy  input  1  global ready; 0 freezes all state
flush_i  input  1  branch/jump redirect; aborts current fetch
req_i  input  1  fetch request from IF
pc_i  input  ADDR_WIDTH  fetch address, word aligned
icache_hit_i  input  1  icache hit for raddr==pc_i (combinational from icache)
icache_inst_i  input  32  icache hit data
icache_raddr_o  output  ADDR_WIDTH  icache read address (=pc_i, combinational)
icache_we_o  output  1  icache fill write enable
icache_waddr_o  output  ADDR_WIDTH  fill address
icache_winst_o  output  32  fill word
mem_req_o  output  1  memory bus request
mem_grant_i  input  1  arbiter grant for this cycle
mem_addr_o  output  ADDR_WIDTH  byte address
mem_din_i  input  8  read byte; valid one cycle after a granted address
inst_valid_o  output  1  one-cycle pulse: instruction delivered
inst_o  output  32  delivered instruction
inst_pc_o  output  ADDR_WIDTH  PC of delivered instruction

Behaviour:
- Reset (rst==0 at posedge): state IDLE; all outputs other than icache_raddr_o are 0; issue/capture counters, pending flag and byte buffer are cleared.
- rdy==0: no register changes. Registered outputs hold their values.
- Priority per edge: reset > rdy==0 freeze > flush_i > normal operation.
- States: IDLE, FETCH.
- IDLE, req_i=1, icache_hit_i=1: at the next edge, inst_valid_o=1, inst_o=icache_inst_i, inst_pc_o=pc_i. State stays IDLE. Hit latency is 1 cycle.
- IDLE, req_i=1, icache_hit_i=0: latch base=pc_i. Set issue_cnt=0 and cap_cnt=0. Set mem_req_o=1 and mem_addr_o=base. Go to FETCH.
- req_i is sampled only in IDLE. In FETCH it is ignored, and IF must hold pc_i stable until inst_valid_o.
- FETCH, issue: in a cycle with mem_req_o=1 and mem_grant_i=1, byte issue_cnt is issued.
  - At the edge, issue_cnt increments, pending is set to 1 and mem_addr_o becomes base+issue_cnt+1.
  - After the 4th issue, mem_req_o drops to 0.
  - If mem_grant_i=0, issue_cnt and mem_addr_o hold, and pending is cleared at the edge.
- FETCH, capture: if pending=1, mem_din_i is byte cap_cnt and is written to buf[8*cap_cnt+7 : 8*cap_cnt] (little-endian). cap_cnt then increments.
- Completion, on the edge capturing byte 3:
  - inst_o={mem_din_i,buf[23:0]}; inst_valid_o=1; inst_pc_o=base.
  - icache_we_o=1; icache_waddr_o=base; icache_winst_o is the same word.
  - State returns to IDLE.
- Miss latency with continuous grant: request edge E0; bytes captured at E2, E3, E4, E5; inst_valid_o and icache_we_o are high in the cycle after E5.
- inst_valid_o and icache_we_o are single-cycle pulses, cleared on the next non-frozen edge.
- Next request: accepted from IDLE at the earliest on the edge after completion.
- flush_i=1:
  - State goes to IDLE; mem_req_o=0; pending=0; counters are cleared.
  - inst_valid_o=0 and icache_we_o=0 at that edge, even if the completion would coincide. No partial fill is ever written.
  - req_i in the same cycle as flush_i is ignored.
- Address arithmetic: base+k is modulo 2^ADDR_WIDTH, so wrap-around at the top address is allowed.
- Grant loss mid-burst: a byte already issued is still captured on the next edge. Issue resumes at the same address once grant returns.

Test Plan:
- Hit: icache_hit_i=1, icache_inst_i=0x00A00093, pc_i=0x1000, req_i pulse -> next cycle inst_valid_o=1, inst_o=0x00A00093, inst_pc_o=0x1000, icache_we_o=0, mem_req_o never 1.
- Miss, full grant: pc_i=0x0004, memory bytes at 0x04..0x07 = 13,05,10,00 -> mem_addr_o=0x04,0x05,0x06,0x07 on consecutive cycles; inst_o=0x00100513 and icache_we_o=1 with waddr 0x0004, 6 cycles after the request cycle.
- Grant gaps: same as the full-grant miss, with mem_grant_i low on the 2nd and 3rd FETCH cycles -> address 0x05 held during the gap, same final word, completion 2 cycles later.
- Flush mid-burst: flush_i after 2 bytes are captured -> mem_req_o=0 next cycle; no icache_we_o and no inst_valid_o; a new request at 0x2000 then starts at mem_addr_o=0x2000.
- rdy freeze: rdy=0 for 3 cycles in mid-FETCH -> mem_addr_o, counters and outputs unchanged; completion delayed by exactly 3 cycles with the correct word.
- Reset mid-fetch: rst=0 for 1 cycle during FETCH -> all outputs 0 next cycle, state IDLE; a following miss completes normally.
